// File: rtl/common_pkg.sv
// Shared types for the memory stage: widths, access sizes, load FSM states
// and the alignment predicate used by both the load and store paths.
package common;

  typedef logic [63:0] u64;
  typedef logic [2:0]  u3;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } load_state_t;

  // An access is misaligned when the low address bits below its size are nonzero.
  function automatic logic misaligned(input u3 addr, input msize_t msize);
    logic result;
    result = 1'b0;
    case (msize)
      MSIZE1: result = 1'b0;
      MSIZE2: result = addr[0];
      MSIZE4: result = (addr[1:0] != 2'b00);
      MSIZE8: result = (addr[2:0] != 3'b000);
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/load_unit_readdata.sv
// Read-side lane aligner: picks the addressed lanes out of a 64-bit bus word
// and sign- or zero-extends them to 64 bits.
module readdata
  import common::*;
(
  input  u3      addr,
  input  u64     data,
  input  msize_t msize,
  input  logic   sign_ext,
  output u64     result
);

  logic [5:0] shamt;
  u64         shifted;

  // Shift the selected lane down to bit 0, then extend from its MSB.
  always_comb begin
    shamt   = 6'd0;
    result  = '0;
    case (msize)
      MSIZE1: shamt = {addr, 3'b000};
      MSIZE2: shamt = {addr[2:1], 4'b0000};
      MSIZE4: shamt = {addr[2], 5'b00000};
      MSIZE8: shamt = 6'd0;
      default: shamt = 6'd0;
    endcase
    shifted = data >> shamt;
    case (msize)
      MSIZE1: result = {{56{sign_ext & shifted[7]}}, shifted[7:0]};
      MSIZE2: result = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
      MSIZE4: result = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
      MSIZE8: result = shifted;
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Memory-stage load engine: one load at a time, issues it on the data bus,
// extracts and extends the result, and holds it until the pipeline takes it.
module load_unit
  import common::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  msize_t      req_msize,
  input  logic        req_signed,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output msize_t      dreq_size,
  output logic [7:0]  dreq_strobe,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_misalign
);

  load_state_t state, state_next;

  u64     addr_q;
  msize_t msize_q;
  logic   signed_q;
  logic   kill_q;
  u64     data_q;
  logic   misalign_q;
  u64     extracted;

  logic accept;
  logic req_misaligned;
  logic in_bus;

  assign accept         = (state == IDLE) && req_valid && !flush;
  assign req_misaligned = misaligned(req_addr[2:0], req_msize);
  assign in_bus         = (state == ADDR) || (state == DATA);

  readdata u_readdata (
    .addr     (addr_q[2:0]),
    .data     (dresp_data),
    .msize    (msize_q),
    .sign_ext (signed_q),
    .result   (extracted)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a killed load still waits for its data before leaving the bus.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = req_misaligned ? DONE : ADDR;
      end
      ADDR: begin
        if (dresp_data_ok)      state_next = (kill_q || flush) ? IDLE : DONE;
        else if (dresp_addr_ok) state_next = DATA;
      end
      DATA: begin
        if (dresp_data_ok) state_next = (kill_q || flush) ? IDLE : DONE;
      end
      DONE: begin
        if (flush || rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready  = 1'b0;
    dreq_valid = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE:    req_ready  = 1'b1;
      ADDR:    dreq_valid = 1'b1;
      DATA:    dreq_valid = 1'b1;
      DONE:    rsp_valid  = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Request capture, kill tracking and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      msize_q    <= MSIZE1;
      signed_q   <= 1'b0;
      kill_q     <= 1'b0;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        msize_q    <= req_msize;
        signed_q   <= req_signed;
        kill_q     <= 1'b0;
        data_q     <= '0;
        misalign_q <= req_misaligned;
      end else if (in_bus) begin
        if (dresp_data_ok) begin
          kill_q <= 1'b0;
          if (!(kill_q || flush)) data_q <= extracted;
        end else if (flush) begin
          kill_q <= 1'b1;
        end
      end
    end
  end

  assign dreq_addr    = addr_q;
  assign dreq_size    = msize_q;
  assign dreq_strobe  = 8'h00;
  assign rsp_data     = data_q;
  assign rsp_misalign = misalign_q;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: directed loads push their expected response,
// a negedge monitor pops and compares on every response handshake.
module tb_load_unit;
  import common::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  msize_t      req_msize;
  logic        req_signed;
  logic        flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  msize_t      dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_misalign;

  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_exp;

  load_unit dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_msize     (req_msize),
    .req_signed    (req_signed),
    .flush         (flush),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_misalign  (rsp_misalign)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid     = 1'b0;
    flush         = 1'b0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    rsp_ready     = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [63:0] addr, input msize_t msize, input logic sgn);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_msize  = msize;
    req_signed = sgn;
    tick();
    req_valid  = 1'b0;
  endtask

  // Full aligned load: addr_ok at issue cycle addr_dly, data_ok at data_dly, then consume.
  task automatic run_load(input string name, input logic [63:0] addr, input msize_t msize,
                          input logic sgn, input logic [63:0] data, input logic [63:0] expected,
                          input int addr_dly, input int data_dly);
    exp_q.push_back({1'b0, expected});
    apply_stimulus(addr, msize, sgn);
    dresp_data = data;
    for (int k = 0; k <= data_dly; k++) begin
      check_output({name, "_dreq_valid"}, {63'b0, dreq_valid}, 64'd1);
      check_output({name, "_dreq_addr"}, dreq_addr, addr);
      check_output({name, "_no_early_rsp"}, {63'b0, rsp_valid}, 64'd0);
      dresp_addr_ok = (k == addr_dly);
      dresp_data_ok = (k == data_dly);
      tick();
    end
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    check_output({name, "_rsp_valid"}, {63'b0, rsp_valid}, 64'd1);
    check_output({name, "_dreq_dropped"}, {63'b0, dreq_valid}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_output({name, "_req_ready_after"}, {63'b0, req_ready}, 64'd1);
    check_output({name, "_rsp_gone"}, {63'b0, rsp_valid}, 64'd0);
  endtask

  // Monitor: compares each consumed response against the scoreboard head.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp: got data %h misalign %0b, want no response", rsp_data, rsp_misalign);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("sb_rsp_data", rsp_data, mon_exp[63:0]);
        check_output("sb_rsp_misalign", {63'b0, rsp_misalign}, {63'b0, mon_exp[64]});
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_inputs();
    req_addr   = '0;
    req_msize  = MSIZE1;
    req_signed = 1'b0;
    dresp_data = '0;
    reset      = 1'b0;
    repeat (3) tick();
    check_output("reset_req_ready", {63'b0, req_ready}, 64'd1);
    check_output("reset_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    check_output("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check_output("reset_rsp_data", rsp_data, 64'd0);
    check_output("reset_dreq_addr", dreq_addr, 64'd0);
    reset = 1'b1;
    tick();

    $display("[TB] LB signed, data_ok two cycles after issue");
    run_load("lb_signed", 64'h0000_0000_0000_1003, MSIZE1, 1'b1,
             64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0, 2);
    check_output("strobe_read", {56'b0, dreq_strobe}, 64'd0);

    $display("[TB] LHU, addr_ok and data_ok together");
    run_load("lhu", 64'h0000_0000_0000_2006, MSIZE2, 1'b0,
             64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF, 0, 0);

    run_load("lh_signed", 64'h0000_0000_0000_3002, MSIZE2, 1'b1,
             64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 1, 1);
    run_load("lwu", 64'h0000_0000_0000_4004, MSIZE4, 1'b0,
             64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 0, 1);
    run_load("lbu_top", 64'h0000_0000_0000_5007, MSIZE1, 1'b0,
             64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5, 0, 1);
    run_load("ld_signed_ignored", 64'h0000_0000_0000_6008, MSIZE8, 1'b1,
             64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 2, 3);

    $display("[TB] LW misaligned");
    exp_q.push_back({1'b1, 64'd0});
    apply_stimulus(64'h0000_0000_0000_7002, MSIZE4, 1'b1);
    check_output("mis_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    check_output("mis_flag", {63'b0, rsp_misalign}, 64'd1);
    check_output("mis_data", rsp_data, 64'd0);
    check_output("mis_no_bus", {63'b0, dreq_valid}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_output("mis_no_bus_after", {63'b0, dreq_valid}, 64'd0);
    check_output("mis_req_ready", {63'b0, req_ready}, 64'd1);

    $display("[TB] LD held for five cycles");
    exp_q.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
    apply_stimulus(64'h0000_0000_0000_8010, MSIZE8, 1'b0);
    dresp_data    = 64'h0123_4567_89AB_CDEF;
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int k = 0; k < 5; k++) begin
      check_output("ld_hold_valid", {63'b0, rsp_valid}, 64'd1);
      check_output("ld_hold_data", rsp_data, 64'h0123_4567_89AB_CDEF);
      check_output("ld_hold_no_ready", {63'b0, req_ready}, 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_output("ld_req_ready_after", {63'b0, req_ready}, 64'd1);

    $display("[TB] flush in DATA");
    apply_stimulus(64'h0000_0000_0000_9001, MSIZE1, 1'b0);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_output("flush_dreq_held", {63'b0, dreq_valid}, 64'd1);
      check_output("flush_no_rsp", {63'b0, rsp_valid}, 64'd0);
      tick();
    end
    dresp_data    = 64'h1111_2222_3333_4444;
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    check_output("flush_no_rsp_end", {63'b0, rsp_valid}, 64'd0);
    check_output("flush_idle", {63'b0, req_ready}, 64'd1);
    check_output("flush_bus_off", {63'b0, dreq_valid}, 64'd0);

    $display("[TB] flush with request in IDLE");
    req_valid = 1'b1;
    flush     = 1'b1;
    req_addr  = 64'h0000_0000_0000_A000;
    req_msize = MSIZE8;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    check_output("flush_req_rejected", {63'b0, dreq_valid}, 64'd0);
    check_output("flush_req_ready", {63'b0, req_ready}, 64'd1);

    $display("[TB] async reset in ADDR");
    apply_stimulus(64'h0000_0000_0000_B004, MSIZE4, 1'b1);
    check_output("rst_pre_dreq", {63'b0, dreq_valid}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("rst_dreq_cleared", {63'b0, dreq_valid}, 64'd0);
    check_output("rst_req_ready", {63'b0, req_ready}, 64'd1);
    check_output("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check_output("rst_dreq_addr", dreq_addr, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    run_load("post_reset_lw", 64'h0000_0000_0000_C004, MSIZE4, 1'b1,
             64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 0, 1);

    tick();
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
